// File: rtl/fc_sequencer.sv
// fc_sequencer: feature-window buffer, FC-unit sequencer and signed argmax.
// Optional watchdog on the FC result wait: define FC_SEQ_WATCHDOG_EN.
module fc_sequencer #(
  parameter int N_IN  = 30,
  parameter int N_OUT = 8,
  parameter int AW    = $clog2(N_OUT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [23:0]          i_sample,
  output logic                 o_ready,
  output logic [AW-1:0]        o_w_addr,
  input  logic [16*N_IN-1:0]   i_w_row,
  input  logic [15:0]          i_w_bias,
  output logic                 o_fc_start,
  output logic [16*N_IN-1:0]   o_fc_weight,
  output logic [24*N_IN-1:0]   o_fc_data,
  output logic [15:0]          o_fc_bias,
  input  logic [31:0]          i_fc_output,
  input  logic                 i_fc_finished,
  output logic                 o_result_valid,
  output logic [AW-1:0]        o_class,
  output logic [31:0]          o_score,
  output logic                 o_error
);

  localparam int CW = $clog2(N_IN);

  typedef enum logic [2:0] {
    S_FILL, S_FETCH, S_LATCH,
    S_START, S_WAIT, S_OUT
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]      cnt;
  logic [AW-1:0]      neuron;
  logic [23:0]        fbuf [N_IN];
  logic signed [31:0] best_score;
  logic [AW-1:0]      best_idx;

  logic accept, last_smp, take, last_nrn, better;

`ifdef FC_SEQ_WATCHDOG_EN
  logic [3:0] wd;
  logic       timeout;
`endif

  assign o_ready  = (state == S_FILL);
  assign o_w_addr = neuron;
  assign last_smp = (cnt == CW'(N_IN - 1));
  assign last_nrn = (neuron == AW'(N_OUT - 1));
  assign better   = (neuron == '0) ||
                    ($signed(i_fc_output) > best_score);

  for (genvar g = 0; g < N_IN; g++) begin : g_pack
    assign o_fc_data[g*24 +: 24] = fbuf[g];
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    take    = 1'b0;
`ifdef FC_SEQ_WATCHDOG_EN
    timeout = 1'b0;
`endif
    unique case (state)
      S_FILL: begin
        if (i_valid) begin
          accept = 1'b1;
          if (last_smp) state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_fc_finished) begin
          take    = 1'b1;
          state_d = last_nrn ? S_OUT : S_FETCH;
        end
`ifdef FC_SEQ_WATCHDOG_EN
        else if (wd == 4'd7) begin
          timeout = 1'b1;
          state_d = S_FILL;
        end
`endif
      end
      S_OUT:   state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) state <= S_FILL;
    else         state <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      cnt            <= '0;
      neuron         <= '0;
      for (int i = 0; i < N_IN; i++) fbuf[i] <= '0;
      best_score     <= '0;
      best_idx       <= '0;
      o_fc_weight    <= '0;
      o_fc_bias      <= '0;
      o_fc_start     <= 1'b0;
      o_result_valid <= 1'b0;
      o_class        <= '0;
      o_score        <= '0;
    end else begin
      o_fc_start     <= (state_d == S_START);
      o_result_valid <= (state_d == S_OUT);
      if (accept) begin
        fbuf[cnt] <= i_sample;
        cnt       <= last_smp ? '0 : cnt + CW'(1);
        if (last_smp) neuron <= '0;
      end
      if (state == S_LATCH) begin
        o_fc_weight <= i_w_row;
        o_fc_bias   <= i_w_bias;
      end
      if (take) begin
        if (better) begin
          best_score <= $signed(i_fc_output);
          best_idx   <= neuron;
        end
        if (!last_nrn) neuron <= neuron + AW'(1);
        // final verdict must include the last neuron's own result
        if (last_nrn) begin
          o_class <= better ? neuron : best_idx;
          o_score <= better ? i_fc_output : best_score;
        end
      end
`ifdef FC_SEQ_WATCHDOG_EN
      if (timeout) cnt <= '0;
`endif
    end
  end

`ifdef FC_SEQ_WATCHDOG_EN
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      wd      <= '0;
      o_error <= 1'b0;
    end else begin
      o_error <= timeout;
      if (state == S_START)     wd <= '0;
      else if (state == S_WAIT) wd <= wd + 4'd1;
    end
  end
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: behavioural FC unit + registered ROM, argmax scoreboard.
// Watchdog checks compile in when FC_SEQ_WATCHDOG_EN is defined.
module tb_fc_sequencer;
  localparam int N_IN  = 30;
  localparam int N_OUT = 8;
  localparam int AW    = 3;

  typedef struct {
    logic [AW-1:0]      cls;
    logic signed [31:0] score;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                 valid = 1'b0;
  logic [23:0]          sample = '0;
  logic                 ready;
  logic [AW-1:0]        w_addr;
  logic [16*N_IN-1:0]   w_row = '0;
  logic [15:0]          w_bias = '0;
  logic                 fc_start;
  logic [16*N_IN-1:0]   fc_weight;
  logic [24*N_IN-1:0]   fc_data;
  logic [15:0]          fc_bias;
  logic [31:0]          fc_output;
  logic                 fc_finished;
  logic                 result_valid;
  logic [AW-1:0]        cls;
  logic [31:0]          score;
  logic                 error;

  fc_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .i_sample(sample), .o_ready(ready),
    .o_w_addr(w_addr), .i_w_row(w_row), .i_w_bias(w_bias),
    .o_fc_start(fc_start), .o_fc_weight(fc_weight),
    .o_fc_data(fc_data), .o_fc_bias(fc_bias),
    .i_fc_output(fc_output), .i_fc_finished(fc_finished),
    .o_result_valid(result_valid), .o_class(cls),
    .o_score(score), .o_error(error)
  );

  logic signed [15:0] wrom [N_OUT][N_IN];
  logic signed [15:0] brom [N_OUT];
  logic signed [23:0] smp  [N_IN];

  always @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) w_row[i*16 +: 16] <= wrom[w_addr][i];
    w_bias <= brom[w_addr];
  end

  function automatic logic signed [31:0] fc_calc();
    longint acc;
    acc = 0;
    for (int i = 0; i < N_IN; i++)
      acc += longint'($signed(fc_data[i*24 +: 24])) *
             longint'($signed(fc_weight[i*16 +: 16]));
    return 32'(acc >>> 8) + 32'($signed(fc_bias));
  endfunction

  int fst = 0;
  bit stall = 1'b0;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fst <= 0;
      fc_output <= '0;
    end else begin
      case (fst)
        0: if (fc_start) fst <= 1;
        1: if (!stall) begin fst <= 2; fc_output <= fc_calc(); end
        default: fst <= 0;
      endcase
    end
  end
  assign fc_finished = (fst == 2);

  function automatic exp_t model();
    exp_t e;
    longint acc;
    logic signed [31:0] s;
    e.cls = '0;
    e.score = '0;
    for (int k = 0; k < N_OUT; k++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++)
        acc += longint'(smp[i]) * longint'(wrom[k][i]);
      s = 32'(acc >>> 8) + 32'(brom[k]);
      if (k == 0 || s > e.score) begin
        e.cls = AW'(k);
        e.score = s;
      end
    end
    return e;
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  exp_t sbq[$];
  exp_t last_e;
  int cyc = 0;
  int n_acc, n_start, first_acc, res_cyc, leak;
  int start_cyc, err_cyc;
  bit computing;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (computing && ready) leak++;
      if (valid && ready) begin
        if (first_acc < 0) first_acc = cyc;
        n_acc++;
        if (n_acc == N_IN) computing = 1'b1;
      end
      if (fc_start) begin n_start++; start_cyc = cyc; end
      if (error) err_cyc = cyc;
      if (result_valid) begin
        computing = 1'b0;
        res_cyc = cyc;
        if (sbq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          last_e = sbq.pop_front();
          chk("class", cls, last_e.cls);
          chk("score", $signed(score), last_e.score);
        end
      end
    end
  end

  task automatic load(input int p);
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        case (p)
          4: wrom[k][i] = 16'($urandom_range(0, 2047)) - 16'sd1024;
          default: wrom[k][i] = 16'sh0100;
        endcase
      end
      case (p)
        1: brom[k] = 16'(k * 256);
        2: brom[k] = 16'sh0100;
        3: brom[k] = (k == 3) ? 16'sh0100 : 16'shFF00;
        default: brom[k] = 16'($urandom_range(0, 65535));
      endcase
    end
    for (int i = 0; i < N_IN; i++) begin
      case (p)
        3: smp[i] = '0;
        4: smp[i] = 24'($urandom_range(0, 2047)) - 24'sd1024;
        default: smp[i] = 24'sh000100;
      endcase
    end
  endtask

  task automatic send(input bit toggle, input bit hold);
    int j;
    int guard;
    bit ph;
    j = 0; guard = 0; ph = 1'b0;
    n_acc = 0; n_start = 0; first_acc = -1;
    leak = 0; computing = 1'b0;
    while (j < N_IN && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
      if (toggle && ph) begin
        valid = 1'b0;
        sample = 24'h7FFFFF;
      end else begin
        valid = 1'b1;
        sample = smp[j];
      end
      ph = ~ph;
      if (valid && ready) j++;
    end
    if (j < N_IN) chk("fill_timeout", j, N_IN);
    @(posedge clk); #1;
    valid = hold;
    sample = 24'h7FFFFF;
  endtask

  task automatic wait_result(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (result_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic window(input int p, input bit toggle, input bit hold);
    bit got;
    load(p);
    sbq.push_back(model());
    send(toggle, hold);
    wait_result(300, got);
    valid = 1'b0;
    chk("result_seen", got, 1);
    @(negedge clk);
    chk("pulse_1cyc", result_valid, 0);
    chk("accepted", n_acc, N_IN);
    chk("fc_starts", n_start, N_OUT);
    chk("ready_low", leak, 0);
  endtask

  task automatic reset_checks();
    chk("rst_ready", ready, 1);
    chk("rst_start", fc_start, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_class", cls, 0);
    chk("rst_score", score, 0);
    chk("rst_addr", w_addr, 0);
    chk("rst_bias", fc_bias, 0);
    chk("rst_data", (fc_data == '0), 1);
  endtask

  initial begin
    bit got;
    int guard;
    err_cyc = -1;
    load(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1 rst_n = 1'b0;

    window(1, 1'b0, 1'b1);
    chk("window_cycles", res_cyc - first_acc + 1, N_IN + 5*N_OUT + 1);
    repeat (3) @(negedge clk);
    chk("class_hold", cls, last_e.cls);
    chk("score_hold", $signed(score), last_e.score);

    window(2, 1'b0, 1'b0);
    window(3, 1'b0, 1'b0);
    window(4, 1'b1, 1'b1);
    window(1, 1'b1, 1'b1);

    // abort during neuron 4's wait
    load(1);
    sbq.push_back(model());
    send(1'b0, 1'b0);
    guard = 0;
    while (n_start < 5 && guard < 200) begin
      @(negedge clk); guard++;
    end
    chk("reach_n4", n_start, 5);
    @(posedge clk); #1 rst_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1 rst_n = 1'b0;
    window(1, 1'b0, 1'b0);

    // FC unit that never finishes
    stall = 1'b1;
    load(3);
    send(1'b0, 1'b0);
`ifdef FC_SEQ_WATCHDOG_EN
    guard = 0;
    while (err_cyc < 0 && guard < 60) begin
      @(negedge clk); guard++;
    end
    chk("wd_delay", err_cyc - start_cyc, 9);
    @(negedge clk);
    chk("wd_ready", ready, 1);
    chk("wd_err_pulse", error, 0);
`else
    repeat (60) @(negedge clk);
    chk("stuck_ready", ready, 0);
    chk("stuck_err", err_cyc, -1);
    chk("stuck_starts", n_start, 1);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    window(3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
